// File: rtl/mic1_pkg.sv
`timescale 1ns/1ps
// mic1_pkg: shared types and limits for the MIC1 pin bridge.
package mic1_pkg;

  localparam int unsigned MIC1_MAX_DATA_W = 32;
  localparam int unsigned MIC1_MAX_DEPTH  = 16;

  // Outbound serializer states
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_LOAD     = 2'd1,
    S_SEND     = 2'd2,
    S_WAIT_ACK = 2'd3
  } ser_state_e;

endpackage

// File: rtl/mic1_sync2.sv
`timescale 1ns/1ps
// mic1_sync2: two-flop synchronizer for a single asynchronous level.
// Ports: clk, rst_n (async active-low), i_d async input, o_q synchronized output.
module mic1_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/mic1_pin_bridge.sv
`timescale 1ns/1ps
// mic1_pin_bridge: bridges an 8-bit toggle-strobed pin interface to word-wide valid/ready streams.
// Ports: clk, rst_n (async active-low);
//   pin_in/pin_in_stb            inbound byte + toggle strobe from pins
//   pin_out/pin_out_stb/pin_out_ack  outbound byte, toggle strobe, toggle acknowledge
//   rx_data/rx_valid/rx_ready    assembled inbound word to the core
//   tx_data/tx_valid/tx_ready    outbound word from the core into the TX FIFO
//   rx_ovf/ovf_clr               sticky inbound overflow flag and its clear
//   tx_level                     TX FIFO occupancy
module mic1_pin_bridge
  import mic1_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             pin_in,
  input  logic                   pin_in_stb,
  output logic [7:0]             pin_out,
  output logic                   pin_out_stb,
  input  logic                   pin_out_ack,
  output logic [DATA_W-1:0]      rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  input  logic [DATA_W-1:0]      tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic                   rx_ovf,
  input  logic                   ovf_clr,
  output logic [$clog2(DEPTH):0] tx_level
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  if (DATA_W < 8 || DATA_W > MIC1_MAX_DATA_W || (DATA_W % 8) != 0 ||
      DEPTH < 2 || DEPTH > MIC1_MAX_DEPTH || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_params
    $error("mic1_pin_bridge: unsupported DATA_W/DEPTH");
  end

  // Strobe/ack synchronizers and edge detection
  logic w_in_sync, w_ack_sync;
  logic r_in_prev, r_ack_prev;
  logic w_in_edge, w_ack_edge;

  mic1_sync2 u_sync_in  (.clk(clk), .rst_n(rst_n), .i_d(pin_in_stb),  .o_q(w_in_sync));
  mic1_sync2 u_sync_ack (.clk(clk), .rst_n(rst_n), .i_d(pin_out_ack), .o_q(w_ack_sync));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_prev  <= 1'b0;
      r_ack_prev <= 1'b0;
    end else begin
      r_in_prev  <= w_in_sync;
      r_ack_prev <= w_ack_sync;
    end
  end

  assign w_in_edge  = w_in_sync ^ r_in_prev;
  assign w_ack_edge = w_ack_sync ^ r_ack_prev;

  // Inbound assembly: lane r_cnt receives pin_in, little-endian
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_asm;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_rx_valid;
  logic              r_rx_ovf;
  logic [DATA_W-1:0] w_word;
  logic              w_last_lane, w_rx_take, w_rx_load, w_ovf_set;

  always_comb begin
    w_word = r_asm;
    for (int b = 0; b < int'(BYTES); b++) begin
      if (r_cnt == CNT_W'(b)) w_word[b*8 +: 8] = pin_in;
    end
  end

  assign w_last_lane = (r_cnt == CNT_W'(BYTES - 1));
  assign w_rx_take   = r_rx_valid && rx_ready;
  assign w_rx_load   = w_in_edge && w_last_lane && (!r_rx_valid || w_rx_take);
  assign w_ovf_set   = w_in_edge && w_last_lane && r_rx_valid && !rx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_asm      <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_rx_ovf   <= 1'b0;
    end else begin
      if (w_in_edge) begin
        r_asm <= w_word;
        r_cnt <= w_last_lane ? '0 : CNT_W'(r_cnt + CNT_W'(1));
      end
      if (w_rx_load) begin
        r_rx_data  <= w_word;
        r_rx_valid <= 1'b1;
      end else if (w_rx_take) begin
        r_rx_valid <= 1'b0;
      end
      // A new overflow beats a simultaneous clear
      if (w_ovf_set)    r_rx_ovf <= 1'b1;
      else if (ovf_clr) r_rx_ovf <= 1'b0;
    end
  end

  // TX FIFO: circular buffer with wrap-bit pointers
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W:0]    r_wr_ptr, r_rd_ptr;
  logic [LVL_W-1:0]  r_level, w_level_nxt;
  logic              r_tx_ready;
  logic              w_push, w_pop, w_empty;

  assign w_push  = tx_valid && r_tx_ready;
  assign w_empty = (r_wr_ptr == r_rd_ptr);

  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop)      w_level_nxt = r_level + LVL_W'(1);
    else if (!w_push && w_pop) w_level_nxt = r_level - LVL_W'(1);
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= tx_data;
  end

  // tx_ready stays low through reset and rises on the first clock after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_tx_ready <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + LVL_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + LVL_W'(1);
      r_level    <= w_level_nxt;
      r_tx_ready <= (w_level_nxt != LVL_W'(DEPTH));
    end
  end

  // Serializer FSM
  ser_state_e       r_state, w_state_nxt;
  logic [DATA_W-1:0] r_shift;
  logic [CNT_W-1:0]  r_idx;
  logic [7:0]        r_pin_out, w_out_byte;
  logic              r_pin_out_stb;
  logic              w_send, w_advance, w_idx_last;

  assign w_idx_last = (r_idx == CNT_W'(BYTES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_send      = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: w_state_nxt = S_SEND;
      S_SEND: begin
        w_send      = 1'b1;
        w_state_nxt = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (w_ack_edge) begin
          w_advance   = !w_idx_last;
          w_state_nxt = w_idx_last ? S_IDLE : S_SEND;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_out_byte = '0;
    for (int b = 0; b < int'(BYTES); b++) begin
      if (r_idx == CNT_W'(b)) w_out_byte = r_shift[b*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift       <= '0;
      r_idx         <= '0;
      r_pin_out     <= '0;
      r_pin_out_stb <= 1'b0;
    end else begin
      if (w_pop) begin
        r_shift <= r_mem[r_rd_ptr[PTR_W-1:0]];
        r_idx   <= '0;
      end
      if (w_send) begin
        r_pin_out     <= w_out_byte;
        r_pin_out_stb <= ~r_pin_out_stb;
      end
      if (w_advance) r_idx <= r_idx + CNT_W'(1);
    end
  end

  assign pin_out     = r_pin_out;
  assign pin_out_stb = r_pin_out_stb;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign rx_ovf      = r_rx_ovf;
  assign tx_ready    = r_tx_ready;
  assign tx_level    = r_level;

endmodule
